// File: rtl/approx_monitor_pkg.sv
// Shared types, default widths and the saturating-add helper for the
// approximate-adder error monitor.
package approx_monitor_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int WIDTH_DEF  = 32;
  localparam int WINDOW_DEF = 1024;
  localparam int CNT_W_DEF  = 32;
  localparam int SUM_W_DEF  = 48;

  // Working width of the saturating adder; any SUM_W up to ACC_MAX_W-1 fits.
  localparam int ACC_MAX_W  = 64;

  // Adds inc to acc and clamps to 2^w-1. The MSB of the result flags that
  // the true sum reached 2^w, the low ACC_MAX_W bits carry the clamped sum.
  function automatic logic [ACC_MAX_W:0] sat_add(
    input logic [ACC_MAX_W-1:0] acc,
    input logic [ACC_MAX_W-1:0] inc,
    input int unsigned          w
  );
    logic [ACC_MAX_W:0] one;
    logic [ACC_MAX_W:0] sum;
    logic [ACC_MAX_W:0] lim;
    one = {{ACC_MAX_W{1'b0}}, 1'b1};
    sum = {1'b0, acc} + {1'b0, inc};
    lim = one << w;
    if (sum >= lim) begin
      sat_add = {1'b1, ACC_MAX_W'(lim - one)};
    end else begin
      sat_add = {1'b0, sum[ACC_MAX_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/approx_adder_error_monitor_if.sv
// Sample bus from the adder under test: operands, approximate result and a
// valid/ready handshake.
interface approx_adder_error_monitor_if
  import approx_monitor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] add1;
  logic [WIDTH-1:0] add2;
  logic [WIDTH:0]   approx;

  modport master (output valid, add1, add2, approx, input ready);
  modport slave  (input valid, add1, add2, approx, output ready);

endinterface

// File: rtl/approx_err_dist.sv
// Second pipeline stage: exact sum, absolute error distance and error flag,
// registered together with the stage valid.
module approx_err_dist
  import approx_monitor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vld_p0,
  input  logic [WIDTH-1:0] add1_p0,
  input  logic [WIDTH-1:0] add2_p0,
  input  logic [WIDTH:0]   approx_p0,
  output logic             vld_p1,
  output logic [WIDTH:0]   ed_p1,
  output logic             err_p1
);

  localparam int EW = WIDTH + 1;

  logic [WIDTH:0]          exact;
  logic signed [WIDTH+1:0] diff;
  logic [WIDTH:0]          ed;

  // Difference is signed one bit wider than the result so an overshooting
  // approximation (carry leak in the OR part) still yields a positive distance.
  always_comb begin
    exact = {1'b0, add1_p0} + {1'b0, add2_p0};
    diff  = $signed({1'b0, exact}) - $signed({1'b0, approx_p0});
    ed    = diff[WIDTH+1] ? EW'(-diff) : EW'(diff);
  end

  // Stage 1 -> stage 2 boundary: valid is reset, data is not.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  // Stage 2 data registers.
  always_ff @(posedge clk_i) begin
    ed_p1  <= ed;
    err_p1 <= (ed != '0);
  end

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Error-statistics monitor for approximate adders: accepts WINDOW samples,
// recomputes the exact sum and accumulates error count, summed and maximum
// error distance.
module approx_adder_error_monitor
  import approx_monitor_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WINDOW = WINDOW_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  approx_adder_error_monitor_if.slave  bus,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             sample_cnt_o,
  output logic [CNT_W-1:0]             err_cnt_o,
  output logic [SUM_W-1:0]             ed_sum_o,
  output logic [WIDTH:0]               ed_max_o,
  output logic                         sat_o
);

  state_t             state, state_nxt;
  logic               ready;
  logic               clr_stats;
  logic               hs;
  logic [CNT_W-1:0]   acc_cnt;

  logic               vld_p0;
  logic [WIDTH-1:0]   add1_p0;
  logic [WIDTH-1:0]   add2_p0;
  logic [WIDTH:0]     approx_p0;

  logic               vld_p1;
  logic [WIDTH:0]     ed_p1;
  logic               err_p1;

  logic [ACC_MAX_W:0] sum_next;
  logic               unused_sum_hi;

  assign hs        = bus.valid & ready;
  assign bus.ready = ready;

  // FSM state register; reset overrides a simultaneous start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, ready and statistics-clear decode.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    clr_stats = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          clr_stats = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        ready = (acc_cnt < CNT_W'(WINDOW));
        if (ready && bus.valid && (acc_cnt == CNT_W'(WINDOW - 1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!vld_p0 && !vld_p1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          clr_stats = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == RUN) || (state == DRAIN);
  assign done_o = (state == DONE);

  // Accepted-sample counter that closes the window.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_stats) begin
      acc_cnt <= '0;
    end else if (hs) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

  // Input -> stage 1 boundary: valid reset, captured data unreset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= hs;
    end
  end

  // Stage 1 data capture on each handshake.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      add1_p0   <= bus.add1;
      add2_p0   <= bus.add2;
      approx_p0 <= bus.approx;
    end
  end

  approx_err_dist #(.WIDTH(WIDTH)) u_err_dist (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .vld_p0    (vld_p0),
    .add1_p0   (add1_p0),
    .add2_p0   (add2_p0),
    .approx_p0 (approx_p0),
    .vld_p1    (vld_p1),
    .ed_p1     (ed_p1),
    .err_p1    (err_p1)
  );

  assign sum_next      = sat_add(ACC_MAX_W'(ed_sum_o), ACC_MAX_W'(ed_p1), SUM_W);
  assign unused_sum_hi = |sum_next[ACC_MAX_W-1:SUM_W];

  // Stage 2 -> accumulator boundary: statistics update.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_stats) begin
      sample_cnt_o <= '0;
      err_cnt_o    <= '0;
      ed_sum_o     <= '0;
      ed_max_o     <= '0;
      sat_o        <= 1'b0;
    end else if (vld_p1) begin
      sample_cnt_o <= sample_cnt_o + CNT_W'(1);
      err_cnt_o    <= err_cnt_o + CNT_W'(err_p1);
      ed_sum_o     <= sum_next[SUM_W-1:0];
      sat_o        <= sat_o | sum_next[ACC_MAX_W];
      if (ed_p1 > ed_max_o) begin
        ed_max_o <= ed_p1;
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed-plus-random bench for the approximate-adder error monitor:
// a WINDOW=4 / SUM_W=34 instance and a WINDOW=1 / SUM_W=48 instance.
module tb_approx_adder_error_monitor;

  localparam int W    = 32;
  localparam int WIN  = 4;
  localparam int CW   = 32;
  localparam int SW   = 34;
  localparam int WIN1 = 1;
  localparam int SW1  = 48;

  logic clk = 1'b0;
  logic rst, start, start1;
  always #5 clk = ~clk;

  approx_adder_error_monitor_if #(.WIDTH(W)) bus  ();
  approx_adder_error_monitor_if #(.WIDTH(W)) bus1 ();

  logic          busy, done, sat;
  logic [CW-1:0] sample_cnt, err_cnt;
  logic [SW-1:0] ed_sum;
  logic [W:0]    ed_max;

  logic           busy1, done1, sat1;
  logic [CW-1:0]  sample_cnt1, err_cnt1;
  logic [SW1-1:0] ed_sum1;
  logic [W:0]     ed_max1;

  approx_adder_error_monitor #(.WIDTH(W), .WINDOW(WIN), .CNT_W(CW), .SUM_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus),
    .busy_o(busy), .done_o(done), .sample_cnt_o(sample_cnt), .err_cnt_o(err_cnt),
    .ed_sum_o(ed_sum), .ed_max_o(ed_max), .sat_o(sat)
  );

  approx_adder_error_monitor #(.WIDTH(W), .WINDOW(WIN1), .CNT_W(CW), .SUM_W(SW1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .bus(bus1),
    .busy_o(busy1), .done_o(done1), .sample_cnt_o(sample_cnt1), .err_cnt_o(err_cnt1),
    .ed_sum_o(ed_sum1), .ed_max_o(ed_max1), .sat_o(sat1)
  );

  typedef struct {
    logic [W-1:0] a1;
    logic [W-1:0] a2;
    logic [W:0]   ap;
  } smp_t;

  smp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic smp_t mk(input logic [W-1:0] a1, input logic [W-1:0] a2, input logic [W:0] ap);
    smp_t s;
    s.a1 = a1;
    s.a2 = a2;
    s.ap = ap;
    return s;
  endfunction

  // Random sample: exact, overshoot, undershoot or lower-part-OR style result.
  function automatic smp_t gen(input int mode);
    logic [W-1:0] a1, a2;
    logic [W:0]   ex, ap, mask, hi;
    int           k;
    a1 = $urandom;
    a2 = $urandom;
    ex = {1'b0, a1} + {1'b0, a2};
    case (mode)
      0:       ap = ex;
      1:       ap = ex + (W+1)'($urandom_range(0, 255));
      2:       ap = ex - (W+1)'($urandom_range(0, 255));
      default: begin
        k    = $urandom_range(1, 12);
        mask = ((W+1)'(1) << k) - (W+1)'(1);
        hi   = ({1'b0, a1} >> k) + ({1'b0, a2} >> k);
        ap   = (hi << k) | ({1'b0, a1 | a2} & mask);
      end
    endcase
    return mk(a1, a2, ap);
  endfunction

  task automatic drive(input int sel, input logic v, input smp_t s);
    if (sel == 0) begin
      bus.valid = v; bus.add1 = s.a1; bus.add2 = s.a2; bus.approx = s.ap;
    end else begin
      bus1.valid = v; bus1.add1 = s.a1; bus1.add2 = s.a2; bus1.approx = s.ap;
    end
  endtask

  // Offer one sample after an optional idle gap and hold it until accepted.
  task automatic send(input int sel, input smp_t s, input int gap_max);
    int   g;
    int   n;
    logic got;
    g = $urandom_range(0, gap_max);
    repeat (g) tick();
    drive(sel, 1'b1, s);
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = (sel == 0) ? bus.ready : bus1.ready;
      tick();
      n++;
    end
    check("handshake", 64'(got), 64'(1));
    if (got) q.push_back(s);
    drive(sel, 1'b0, s);
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start = 1'b1; else start1 = 1'b1;
    tick();
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int   n;
    logic d, r;
    n = 0;
    d = (sel == 0) ? done : done1;
    while (!d && n < 30) begin
      tick();
      n++;
      d = (sel == 0) ? done : done1;
    end
    r = (sel == 0) ? bus.ready : bus1.ready;
    check("done_rise", 64'(d), 64'(1));
    check("ready_done", 64'(r), 64'(0));
  endtask

  // Reference statistics of the accepted samples, from plain integer arithmetic.
  task automatic expect_stats(input string tag, input int sel);
    longint unsigned tsum, mx, ec, lim, esum, ex, ap, ed;
    int              sw;
    logic [63:0]     o_cnt, o_err, o_sum, o_max, o_sat;
    tsum = 0; mx = 0; ec = 0;
    sw   = (sel == 0) ? SW : SW1;
    foreach (q[i]) begin
      ex = 64'(q[i].a1) + 64'(q[i].a2);
      ap = 64'(q[i].ap);
      ed = (ex >= ap) ? ex - ap : ap - ex;
      tsum += ed;
      if (ed != 0) ec++;
      if (ed > mx) mx = ed;
    end
    lim  = 64'(1) << sw;
    esum = (tsum >= lim) ? lim - 1 : tsum;
    if (sel == 0) begin
      o_cnt = 64'(sample_cnt); o_err = 64'(err_cnt); o_sum = 64'(ed_sum);
      o_max = 64'(ed_max); o_sat = 64'(sat);
    end else begin
      o_cnt = 64'(sample_cnt1); o_err = 64'(err_cnt1); o_sum = 64'(ed_sum1);
      o_max = 64'(ed_max1); o_sat = 64'(sat1);
    end
    check({tag, "_cnt"},  o_cnt, 64'(q.size()));
    check({tag, "_err"},  o_err, ec);
    check({tag, "_sum"},  o_sum, esum);
    check({tag, "_max"},  o_max, mx);
    check({tag, "_sat"},  o_sat, 64'(tsum >= lim));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 64'(bus.ready), 0);
    check({tag, "_busy"},  64'(busy), 0);
    check({tag, "_done"},  64'(done), 0);
    check({tag, "_cnt"},   64'(sample_cnt), 0);
    check({tag, "_err"},   64'(err_cnt), 0);
    check({tag, "_sum"},   64'(ed_sum), 0);
    check({tag, "_max"},   64'(ed_max), 0);
    check({tag, "_sat"},   64'(sat), 0);
  endtask

  initial begin
    smp_t z;
    z = mk('0, '0, '0);
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    drive(0, 1'b0, z);
    drive(1, 1'b0, z);
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;

    // IDLE ignores valid
    drive(0, 1'b1, mk(32'h1, 32'h2, 33'h0));
    repeat (3) tick();
    drive(0, 1'b0, z);
    check("idle_ready", 64'(bus.ready), 0);
    tick();
    tick();
    check("idle_cnt", 64'(sample_cnt), 0);

    // Exact samples, back to back
    q.delete();
    pulse_start(0);
    check("run_busy", 64'(busy), 1);
    check("run_ready", 64'(bus.ready), 1);
    for (int i = 0; i < WIN; i++) send(0, gen(0), 0);
    check("drain_ready", 64'(bus.ready), 0);
    check("drain_busy", 64'(busy), 1);
    wait_done(0);
    check("acc_window", 64'(q.size()), 64'(WIN));
    expect_stats("exact", 0);

    // Undershoot and overshoot directed samples
    q.delete();
    pulse_start(0);
    send(0, mk(32'h0000000F, 32'h00000001, 33'h00000000F), 0);
    send(0, mk(32'h000000FF, 32'h000000FF, 33'h0000001FF), 0);
    send(0, gen(0), 1);
    send(0, gen(0), 1);
    wait_done(0);
    expect_stats("usos", 0);

    // DONE ignores valid and holds statistics
    drive(0, 1'b1, mk(32'h5, 32'h5, 33'h0));
    repeat (3) tick();
    drive(0, 1'b0, z);
    tick(); tick();
    check("done_hold", 64'(done), 1);
    check("done_frozen_ready", 64'(bus.ready), 0);
    expect_stats("frozen", 0);

    // Saturation of the 34-bit accumulator
    q.delete();
    pulse_start(0);
    for (int i = 0; i < WIN; i++) send(0, mk(32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0), 0);
    wait_done(0);
    check("sat_peg", 64'(ed_sum), 64'h3FFFFFFFF);
    expect_stats("sat", 0);

    // Random runs with gaps and ignored start pulses in RUN and DRAIN
    for (int r = 0; r < 6; r++) begin
      q.delete();
      pulse_start(0);
      for (int i = 0; i < WIN; i++) begin
        send(0, gen($urandom_range(0, 3)), 3);
        if (i == 1) pulse_start(0);
      end
      check("rnd_drain_ready", 64'(bus.ready), 0);
      pulse_start(0);
      wait_done(0);
      expect_stats("rnd", 0);
    end

    // Reset mid-run, then a clean run
    q.delete();
    pulse_start(0);
    for (int i = 0; i < 3; i++) send(0, gen(3), 0);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    tick();
    check("midrst_idle", 64'(busy), 0);
    q.delete();
    pulse_start(0);
    for (int i = 0; i < WIN; i++) send(0, gen($urandom_range(1, 3)), 2);
    wait_done(0);
    expect_stats("clean", 0);

    // Reset and start together from DONE: reset wins
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_start_busy", 64'(busy), 0);
    check("rst_start_done", 64'(done), 0);
    check("rst_start_cnt", 64'(sample_cnt), 0);

    // WINDOW=1 instance
    for (int r = 0; r < 2; r++) begin
      q.delete();
      pulse_start(1);
      check("w1_ready", 64'(bus1.ready), 1);
      send(1, gen(r == 0 ? 0 : 3), 0);
      check("w1_after_ready", 64'(bus1.ready), 0);
      wait_done(1);
      expect_stats("w1", 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
